// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler: round-robin arbitration of two producers onto the single
// register-file write port, plus a pending-write scoreboard for decode hazards.
module regfile_wb_scheduler #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [4:0]        a_rd_i,
  input  logic [DWIDTH-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [4:0]        b_rd_i,
  input  logic [DWIDTH-1:0] b_data_i,
  input  logic              issue_i,
  input  logic [4:0]        issue_rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  output logic              hazard_o,
  output logic [31:0]       pending_o,
  output logic [4:0]        rd_o,
  output logic [DWIDTH-1:0] datawb_o,
  output logic              regwren_o
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  prio_e             r_prio;
  logic [4:0]        r_rd;
  logic [DWIDTH-1:0] r_data;
  logic              r_wren;
  logic [31:0]       r_pending;

  logic              w_a_ready;
  logic              w_b_ready;
  logic              w_a_xfer;
  logic              w_b_xfer;
  logic [31:0]       w_pending_next;

  // Ready looks only at the other port's valid, so there is no valid->ready
  // loop on either port; the two readies are never both high when both valid.
  assign w_a_ready = !(b_valid_i && (r_prio == PRIO_B));
  assign w_b_ready = !(a_valid_i && (r_prio == PRIO_A));
  assign w_a_xfer  = a_valid_i && w_a_ready;
  assign w_b_xfer  = b_valid_i && w_b_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prio <= PRIO_A;
    end else if (w_a_xfer) begin
      r_prio <= PRIO_B;
    end else if (w_b_xfer) begin
      r_prio <= PRIO_A;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement or block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd   <= '0;
      r_data <= '0;
      r_wren <= 1'b0;
    end else begin
      r_wren <= 1'b0;
      if (w_a_xfer) begin
        r_rd   <= a_rd_i;
        r_data <= a_data_i;
        r_wren <= (a_rd_i != 5'd0);
      end else if (w_b_xfer) begin
        r_rd   <= b_rd_i;
        r_data <= b_data_i;
        r_wren <= (b_rd_i != 5'd0);
      end
    end
  end

  // NOTE: the default assignment first keeps this block latch-free; the set
  // follows the clear so a same-edge reservation of the committing register wins.
  always_comb begin
    w_pending_next = r_pending;
    if (r_wren) begin
      w_pending_next[r_rd] = 1'b0;
    end
    if (issue_i && (issue_rd_i != 5'd0)) begin
      w_pending_next[issue_rd_i] = 1'b1;
    end
    w_pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_next;
    end
  end

  // Bit 0 of the scoreboard is never set, so x0 cannot raise a hazard.
  assign hazard_o  = r_pending[rs1_i] | r_pending[rs2_i] |
                     (issue_i & r_pending[issue_rd_i]);

  assign a_ready_o = w_a_ready;
  assign b_ready_o = w_b_ready;
  assign pending_o = r_pending;
  assign rd_o      = r_rd;
  assign datawb_o  = r_data;
  assign regwren_o = r_wren;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler, with a behavioural register file
// attached to the writeback port.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid_i, b_valid_i;
  logic        a_ready_o, b_ready_o;
  logic [4:0]  a_rd_i, b_rd_i;
  logic [31:0] a_data_i, b_data_i;
  logic        issue_i;
  logic [4:0]  issue_rd_i, rs1_i, rs2_i;
  logic        hazard_o;
  logic [31:0] pending_o;
  logic [4:0]  rd_o;
  logic [31:0] datawb_o;
  logic        regwren_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] rf [32] = '{default: 32'h0};

  regfile_wb_scheduler #(.DWIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid_i (a_valid_i),
    .a_ready_o (a_ready_o),
    .a_rd_i    (a_rd_i),
    .a_data_i  (a_data_i),
    .b_valid_i (b_valid_i),
    .b_ready_o (b_ready_o),
    .b_rd_i    (b_rd_i),
    .b_data_i  (b_data_i),
    .issue_i   (issue_i),
    .issue_rd_i(issue_rd_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .hazard_o  (hazard_o),
    .pending_o (pending_o),
    .rd_o      (rd_o),
    .datawb_o  (datawb_o),
    .regwren_o (regwren_o)
  );

  always #5 clk = ~clk;

  // Register file: commits at the rising edge while regwren is high; x0 is hardwired.
  always @(posedge clk) begin
    if (regwren_o && (rd_o != 5'd0)) rf[rd_o] <= datawb_o;
  end

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : rf[idx];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    a_valid_i = 1'b0; a_rd_i = '0; a_data_i = '0;
    b_valid_i = 1'b0; b_rd_i = '0; b_data_i = '0;
    issue_i = 1'b0; issue_rd_i = '0; rs1_i = '0; rs2_i = 5'd2;

    // Reset and idle
    tick(); tick();
    check("rst_regwren", {31'b0, regwren_o}, 32'h0);
    check("rst_rd", {27'b0, rd_o}, 32'h0);
    check("rst_data", datawb_o, 32'h0);
    check("rst_pending", pending_o, 32'h0);
    check("rst_hazard", {31'b0, hazard_o}, 32'h0);

    // Transfers during reset are lost
    a_valid_i = 1'b1; a_rd_i = 5'd3; a_data_i = 32'h0000_0003;
    b_valid_i = 1'b1; b_rd_i = 5'd4; b_data_i = 32'h0000_0004;
    #1;
    check("rst_a_ready", {31'b0, a_ready_o}, 32'h1);
    check("rst_b_ready", {31'b0, b_ready_o}, 32'h0);
    tick();
    check("rst_lost_regwren", {31'b0, regwren_o}, 32'h0);

    // First cycle after release, both valid: prio is A
    rst = 1'b1;
    #1;
    check("rel_a_ready", {31'b0, a_ready_o}, 32'h1);
    check("rel_b_ready", {31'b0, b_ready_o}, 32'h0);
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    tick();
    check("rel_regwren", {31'b0, regwren_o}, 32'h0);

    // Issue x5, then port A writes x5
    issue_i = 1'b1; issue_rd_i = 5'd5; rs2_i = 5'd0;
    #1;
    check("iss5_hazard_pre", {31'b0, hazard_o}, 32'h0);
    tick();
    issue_i = 1'b0; rs1_i = 5'd5;
    #1;
    check("iss5_pending", pending_o, 32'h0000_0020);
    check("iss5_hazard_rs1", {31'b0, hazard_o}, 32'h1);
    rs1_i = 5'd0; rs2_i = 5'd5;
    #1;
    check("iss5_hazard_rs2", {31'b0, hazard_o}, 32'h1);
    rs2_i = 5'd0; issue_i = 1'b1; issue_rd_i = 5'd5;
    #1;
    check("iss5_hazard_issue", {31'b0, hazard_o}, 32'h1);
    issue_i = 1'b0; rs1_i = 5'd5;
    a_valid_i = 1'b1; a_rd_i = 5'd5; a_data_i = 32'h1234_5678;
    #1;
    check("wr5_a_ready", {31'b0, a_ready_o}, 32'h1);
    tick();
    a_valid_i = 1'b0;
    check("wr5_regwren", {31'b0, regwren_o}, 32'h1);
    check("wr5_rd", {27'b0, rd_o}, 32'd5);
    check("wr5_data", datawb_o, 32'h1234_5678);
    check("wr5_hazard_hold", {31'b0, hazard_o}, 32'h1);
    tick();
    check("wr5_regwren_drop", {31'b0, regwren_o}, 32'h0);
    check("wr5_pending_clr", pending_o, 32'h0);
    check("wr5_hazard_clr", {31'b0, hazard_o}, 32'h0);
    check("wr5_rf", rf_read(5'd5), 32'h1234_5678);
    rs1_i = 5'd0;

    // Port B writes x0: accepted, dropped
    b_valid_i = 1'b1; b_rd_i = 5'd0; b_data_i = 32'hDEAD_BEEF;
    #1;
    check("x0_b_ready", {31'b0, b_ready_o}, 32'h1);
    tick();
    b_valid_i = 1'b0;
    check("x0_regwren", {31'b0, regwren_o}, 32'h0);
    check("x0_pending", pending_o, 32'h0);
    tick();
    check("x0_rf", rf_read(5'd0), 32'h0);

    // Contention: grants A, B, A, B with losers holding
    a_valid_i = 1'b1; a_rd_i = 5'd10; a_data_i = 32'h1111_1111;
    b_valid_i = 1'b1; b_rd_i = 5'd20; b_data_i = 32'h2222_2222;
    #1;
    check("c1_a_ready", {31'b0, a_ready_o}, 32'h1);
    check("c1_b_ready", {31'b0, b_ready_o}, 32'h0);
    tick();
    check("c1_rd", {27'b0, rd_o}, 32'd10);
    check("c1_data", datawb_o, 32'h1111_1111);
    a_rd_i = 5'd12; a_data_i = 32'h3333_3333;
    #1;
    check("c2_a_ready", {31'b0, a_ready_o}, 32'h0);
    check("c2_b_ready", {31'b0, b_ready_o}, 32'h1);
    tick();
    check("c2_rd", {27'b0, rd_o}, 32'd20);
    check("c2_data", datawb_o, 32'h2222_2222);
    b_rd_i = 5'd22; b_data_i = 32'h4444_4444;
    tick();
    check("c3_rd", {27'b0, rd_o}, 32'd12);
    check("c3_data", datawb_o, 32'h3333_3333);
    tick();
    check("c4_rd", {27'b0, rd_o}, 32'd22);
    check("c4_data", datawb_o, 32'h4444_4444);
    check("c4_regwren", {31'b0, regwren_o}, 32'h1);
    a_valid_i = 1'b0; b_valid_i = 1'b0;
    tick();
    check("c_idle_regwren", {31'b0, regwren_o}, 32'h0);
    check("c_rf10", rf_read(5'd10), 32'h1111_1111);
    check("c_rf20", rf_read(5'd20), 32'h2222_2222);
    check("c_rf12", rf_read(5'd12), 32'h3333_3333);
    check("c_rf22", rf_read(5'd22), 32'h4444_4444);

    // Same-edge set and clear on x7: set wins
    issue_i = 1'b1; issue_rd_i = 5'd7;
    tick();
    issue_i = 1'b0;
    check("x7_pending_set", pending_o, 32'h0000_0080);
    a_valid_i = 1'b1; a_rd_i = 5'd7; a_data_i = 32'h0000_0077;
    tick();
    a_valid_i = 1'b0;
    check("x7_regwren", {31'b0, regwren_o}, 32'h1);
    issue_i = 1'b1; issue_rd_i = 5'd7;
    tick();
    issue_i = 1'b0;
    check("x7_pending_setwins", pending_o, 32'h0000_0080);

    // Reset between transfer and commit of x9
    a_valid_i = 1'b1; a_rd_i = 5'd9; a_data_i = 32'hABCD_EF00;
    tick();
    a_valid_i = 1'b0;
    check("x9_regwren", {31'b0, regwren_o}, 32'h1);
    check("x9_rd", {27'b0, rd_o}, 32'd9);
    #2;
    rst = 1'b0;
    #1;
    check("x9_rst_regwren", {31'b0, regwren_o}, 32'h0);
    check("x9_rst_rd", {27'b0, rd_o}, 32'h0);
    check("x9_rst_pending", pending_o, 32'h0);
    tick();
    check("x9_rf", rf_read(5'd9), 32'h0);
    rst = 1'b1;
    tick();
    check("x9_post_pending", pending_o, 32'h0);
    check("x9_post_regwren", {31'b0, regwren_o}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Writeback scheduler that shares the single register-file write port between two producers: port A (ALU/execute) and port B (load unit). It arbitrates round-robin and registers the winning write onto the register file's `rd_i`/`datawb_i`/`regwren_i` inputs. It also keeps a 32-entry pending-write scoreboard that decode uses to stall on RAW/WAW hazards. It sits between execute/memory and the register file; decode drives its issue and query ports.

## Interface
- DWIDTH, 32, data width of writeback values
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- a_valid_i  in  1  port A write request
- a_ready_o  out  1  port A request accepted this cycle (combinational)
- a_rd_i  in  5  port A destination register
- a_data_i  in  DWIDTH  port A write data
- b_valid_i  in  1  port B write request
- b_ready_o  out  1  port B request accepted this cycle (combinational)
- b_rd_i  in  5  port B destination register
- b_data_i  in  DWIDTH  port B write data
- issue_i  in  1  decode reserves a destination this cycle
- issue_rd_i  in  5  register being reserved
- rs1_i  in  5  decode source 1 for hazard query
- rs2_i  in  5  decode source 2 for hazard query
- hazard_o  out  1  rs1, rs2 or issue_rd_i is pending (combinational)
- pending_o  out  32  scoreboard bitmap; bit 0 is always 0
- rd_o  out  5  to register file `rd_i`
- datawb_o  out  DWIDTH  to register file `datawb_i`
- regwren_o  out  1  to register file `regwren_i`

## Operation
- Handshake: a transfer occurs on a port when valid and ready are both high at a rising edge. Data and rd must stay stable while valid is high and ready is low.
- Ready rules:
  - One write is granted per cycle.
  - Ready does not depend on the same port's valid.
  - a_ready_o = !(b_valid_i && prio == B).
  - b_ready_o = !(a_valid_i && prio == A).
- Priority register `prio`:
  - After any transfer on port A, prio becomes B.
  - After any transfer on port B, prio becomes A.
  - Unchanged in idle cycles.
- Output register:
  - On a transfer, rd_o and datawb_o load the winner's rd and data.
  - regwren_o loads 1 if the winner's rd != 0, otherwise 0.
  - With no transfer, regwren_o loads 0 and rd_o/datawb_o hold their values.
- Writes to x0 are accepted and dropped: ready asserts normally and regwren_o stays 0.
- Scoreboard `pending[31:0]`:
  - issue_i with issue_rd_i != 0 sets that bit.
  - A cycle with regwren_o == 1 clears pending[rd_o] at the end of that cycle, i.e. the edge at which the register file commits.
  - If set and clear hit the same register at the same edge, set wins.
  - issue_i with rd 0 has no effect.
- hazard_o = pending[rs1_i] | pending[rs2_i] | (issue_i & pending[issue_rd_i]). x0 never raises a hazard.
- Decode must not assert issue_i while hazard_o is high. The scheduler does not guard against this.

## Timing
- Reset (rst low, asynchronous):
  - regwren_o=0, rd_o=0, datawb_o=0, pending=0, prio=A.
  - An accepted-but-uncommitted write is discarded.
  - Ready outputs follow their combinational equations during reset; transfers during reset are lost.
- Latency from transfer at edge N:
  - regwren_o/rd_o/datawb_o are valid in cycle N..N+1.
  - The register file writes at edge N+1.
  - The pending bit clears at edge N+1, so hazard_o drops in the cycle after N+1, when the register file read returns the new value.
- Throughput is one write per cycle sustained. With both ports continuously valid, grants alternate A, B, A, B, starting from the current prio.
- No combinational path from valid to the same port's ready. hazard_o is combinational from rs1_i/rs2_i/issue_i/issue_rd_i and pending.

## Test plan
- Reset, then idle: regwren_o=0, pending_o=0, hazard_o=0 for rs1=0/rs2=2. Release rst; with a_valid_i and b_valid_i both high in the first cycle, a_ready_o=1 and b_ready_o=0.
- Issue x5, then A writes x5=0x12345678:
  - hazard_o=1 for rs1=5 from the cycle after issue.
  - After the transfer, regwren_o=1, rd_o=5, datawb_o=0x12345678 for one cycle.
  - pending_o[5] clears and hazard_o=0 the following cycle; the register file reads x5=0x12345678.
- Contention: A and B both valid for 4 cycles (A: x10=0x11111111, then x12; B: x20=0x22222222, then x22). Grants are A, B, A, B. rd_o sequence is 10, 20, 12, 22, and each loser holds its data stable.
- x0 write: B writes rd=0, data=0xDEADBEEF -> b_ready_o=1, regwren_o stays 0, pending_o stays 0, register file x0 reads 0.
- Same-edge set/clear: a write to x7 commits while issue_i=1, issue_rd_i=7 at the same edge -> pending_o[7]=1 afterwards.
- Reset mid-operation: transfer x9=0xABCDEF00, assert rst before the commit edge -> regwren_o=0 immediately, register file x9 is unchanged, pending_o=0.
